// File: rtl/mops_sdo_pkg.sv
// Shared SDO definitions for the MOPS responder: FSM states, COB-ID bases, commands, indices, aborts, frame layout.
// MOPS_RSP_BOOTUP_EN adds the BOOT state to the state enum.
package mops_sdo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3
`ifdef MOPS_RSP_BOOTUP_EN
    , ST_BOOT = 3'd4
`endif
  } state_e;

  localparam logic [10:0] COB_TSDO_BASE = 11'h580;
  localparam logic [10:0] COB_RSDO_BASE = 11'h600;
  localparam logic [10:0] COB_BOOT_BASE = 11'h700;

  localparam logic [7:0] CMD_UPLOAD_REQ  = 8'h40;
  localparam logic [7:0] CMD_UPLOAD_RSP4 = 8'h43;
  localparam logic [7:0] CMD_UPLOAD_RSP2 = 8'h4B;
  localparam logic [7:0] CMD_DNLOAD_REQ4 = 8'h23;
  localparam logic [7:0] CMD_DNLOAD_RSP  = 8'h60;
  localparam logic [7:0] CMD_ABORT       = 8'h80;

  localparam logic [15:0] IDX_DEVICE_TYPE = 16'h1000;
  localparam logic [15:0] IDX_USER_REG    = 16'h2200;
  localparam logic [15:0] IDX_ADC         = 16'h2400;

  localparam logic [31:0] ABORT_NO_OBJECT = 32'h0602_0000;
  localparam logic [31:0] ABORT_NO_SUB    = 32'h0609_0011;

  // Frame = {pad, COB-ID[10:0], byte0 .. byte7}; byte0 sits at the top of the payload.
  localparam int FRM_W    = 76;
  localparam int COB_LSB  = 64;
  localparam int CMD_LSB  = 56;
  localparam int IDXL_LSB = 48;
  localparam int IDXH_LSB = 40;
  localparam int SUB_LSB  = 32;
  localparam int DATA_LSB = 0;

  // Byte reversal: converts between a 32-bit value and its little-endian byte4..7 image.
  function automatic logic [31:0] le32(input logic [31:0] b);
    return {b[7:0], b[15:8], b[23:16], b[31:24]};
  endfunction

  function automatic logic [FRM_W-1:0] mk_frame(input logic [10:0] cob, input logic [7:0] cmd,
                                               input logic [15:0] idx, input logic [7:0] sub,
                                               input logic [31:0] data);
    logic [FRM_W-1:0] f;
    f = '0;
    f[COB_LSB +: 11]  = cob;
    f[CMD_LSB +: 8]   = cmd;
    f[IDXL_LSB +: 8]  = idx[7:0];
    f[IDXH_LSB +: 8]  = idx[15:8];
    f[SUB_LSB +: 8]   = sub;
    f[DATA_LSB +: 32] = le32(data);
    return f;
  endfunction

endpackage

// File: rtl/mops_od_lookup.sv
// Combinational object-dictionary decode: request cmd/index/sub -> response cmd, data and user-register write enable.
// Zero latency, no flow control; every unsupported access resolves to an abort.
module mops_od_lookup
  import mops_sdo_pkg::*;
#(
  parameter int N_ADC_CH = 32
) (
  input  logic [7:0]  cmd_i,
  input  logic [15:0] index_i,
  input  logic [7:0]  sub_i,
  input  logic [3:0]  node_lo_i,
  input  logic [31:0] user_i,
  output logic [7:0]  rsp_cmd_o,
  output logic [31:0] rsp_data_o,
  output logic        user_we_o
);

  logic adc_sub_ok;
  assign adc_sub_ok = (int'(sub_i) >= 1) && (int'(sub_i) <= N_ADC_CH);

  always_comb begin
    rsp_cmd_o  = CMD_ABORT;
    rsp_data_o = (index_i == IDX_ADC && !adc_sub_ok) ? ABORT_NO_SUB : ABORT_NO_OBJECT;
    user_we_o  = 1'b0;
    if (cmd_i == CMD_UPLOAD_REQ) begin
      if (index_i == IDX_DEVICE_TYPE && sub_i == 8'd0) begin
        rsp_cmd_o  = CMD_UPLOAD_RSP4;
        rsp_data_o = 32'h0;
      end else if (index_i == IDX_USER_REG && sub_i == 8'd0) begin
        rsp_cmd_o  = CMD_UPLOAD_RSP4;
        rsp_data_o = user_i;
      end else if (index_i == IDX_ADC && adc_sub_ok) begin
        rsp_cmd_o  = CMD_UPLOAD_RSP2;
        rsp_data_o = {16'h0, node_lo_i, 2'b00, sub_i[5:0], 4'h0};
      end
    end else if (cmd_i == CMD_DNLOAD_REQ4 && index_i == IDX_USER_REG && sub_i == 8'd0) begin
      rsp_cmd_o  = CMD_DNLOAD_RSP;
      rsp_data_o = 32'h0;
      user_we_o  = 1'b1;
    end
  end

endmodule

// File: rtl/mops_sdo_responder.sv
// Emulated MOPS SDO server: one request in flight, response RSP_LATENCY cycles after acceptance, held until rsp_ready.
// MOPS_RSP_BOOTUP_EN: after reset, send one boot-up frame (0x700+node_id) before serving requests.
module mops_sdo_responder
  import mops_sdo_pkg::*;
#(
  parameter int RSP_LATENCY = 16,
  parameter int N_ADC_CH    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       node_id,
  input  logic [FRM_W-1:0] req_data,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [FRM_W-1:0] rsp_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam logic [7:0] LAT_LAST = 8'(RSP_LATENCY - 2);
`ifdef MOPS_RSP_BOOTUP_EN
  localparam state_e RESET_ST = ST_BOOT;
`else
  localparam state_e RESET_ST = ST_IDLE;
`endif

  state_e           state_q;
  logic [FRM_W-1:0] req_q;
  logic [6:0]       node_q;
  logic [7:0]       cnt_q;
  logic [31:0]      user_q;
  logic [FRM_W-1:0] rsp_q;
  logic             rsp_vld_q;
  logic             req_rdy_q;
  logic             busy_q;

  logic [7:0]       req_cmd;
  logic [15:0]      req_idx;
  logic [7:0]       req_sub;
  logic [31:0]      req_wdata;
  logic [10:0]      rsdo_cob;
  logic             cob_hit;
  logic [7:0]       od_cmd;
  logic [31:0]      od_data;
  logic             od_we;
  logic [FRM_W-1:0] rsp_frame_d;

  assign req_cmd   = req_q[CMD_LSB +: 8];
  assign req_idx   = {req_q[IDXH_LSB +: 8], req_q[IDXL_LSB +: 8]};
  assign req_sub   = req_q[SUB_LSB +: 8];
  assign req_wdata = le32(req_q[DATA_LSB +: 32]);
  assign rsdo_cob  = COB_RSDO_BASE + 11'(node_q);
  assign cob_hit   = (req_q[COB_LSB +: 12] == {1'b0, rsdo_cob});

  mops_od_lookup #(.N_ADC_CH(N_ADC_CH)) u_od (
    .cmd_i      (req_cmd),
    .index_i    (req_idx),
    .sub_i      (req_sub),
    .node_lo_i  (node_q[3:0]),
    .user_i     (user_q),
    .rsp_cmd_o  (od_cmd),
    .rsp_data_o (od_data),
    .user_we_o  (od_we)
  );

  assign rsp_frame_d = mk_frame(COB_TSDO_BASE + 11'(node_q), od_cmd, req_idx, req_sub, od_data);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RESET_ST;
      req_q     <= '0;
      node_q    <= '0;
      cnt_q     <= '0;
      user_q    <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      req_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
          if (req_valid && req_rdy_q) begin
            req_q     <= req_data;
            node_q    <= node_id;
            req_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (cob_hit) begin
            rsp_q   <= rsp_frame_d;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
            if (od_we) user_q <= req_wdata;
          end else begin
            // Frames for other nodes are dropped without a response.
            req_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == LAT_LAST) begin
            rsp_vld_q <= 1'b1;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            req_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
`ifdef MOPS_RSP_BOOTUP_EN
        ST_BOOT: begin
          rsp_q     <= mk_frame(COB_BOOT_BASE + 11'(node_id), 8'h0, 16'h0, 8'h0, 32'h0);
          rsp_vld_q <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= ST_SEND;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_rdy_q;
  assign rsp_data  = rsp_q;
  assign rsp_valid = rsp_vld_q;
  assign busy      = busy_q;

endmodule
